// File: rtl/video_meter_pkg.sv
// Shared types for the video timing meter: FSM states, counter widths and the
// per-frame measurement record.
package video_meter_pkg;

    localparam int unsigned CW_DEF  = 12;
    localparam int unsigned CW_MAX  = 16;
    localparam int unsigned MATCH_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Fields are CW_MAX wide; narrower instances zero-extend into them.
    typedef struct packed {
        logic [CW_MAX-1:0] htotal;
        logic [CW_MAX-1:0] hactive;
        logic [CW_MAX-1:0] vtotal;
        logic [CW_MAX-1:0] vactive;
    } frame_t;

endpackage

// File: rtl/vtm_edge_det.sv
// Input sample stage: registers hs/vs/de once and keeps a one-deep history of
// hs/vs so rising edges are reported aligned with the registered de.
module vtm_edge_det (
    input  logic clk_vid,
    input  logic reset_n,
    input  logic hs,
    input  logic vs,
    input  logic de,
    output logic hs_rise,
    output logic vs_rise,
    output logic de_s
);
    logic [2:0] samp;   // {hs, vs, de}
    logic [1:0] prev;   // {hs, vs}

    // NOTE: non-blocking assignments make prev take samp's old value, forming a real two-stage history.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            samp <= '0;
            prev <= '0;
        end else begin
            samp <= {hs, vs, de};
            prev <= samp[2:1];
        end
    end

    assign hs_rise = samp[2] & ~prev[1];
    assign vs_rise = samp[1] & ~prev[0];
    assign de_s    = samp[0];

endmodule

// File: rtl/video_timing_meter.sv
// Measures the mixer's output raster (pixels per line, lines per frame, active
// extents) and reports it as valid once it has held steady for STABLE_FRAMES.
module video_timing_meter
    import video_meter_pkg::*;
#(
    parameter int unsigned CW            = CW_DEF,
    parameter int unsigned STABLE_FRAMES = 2,
    parameter logic [23:0] TIMEOUT       = 24'd4_000_000
) (
    input  logic          clk_vid,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic          hs,
    input  logic          vs,
    input  logic          de,
    output logic [CW-1:0] htotal,
    output logic [CW-1:0] hactive,
    output logic [CW-1:0] vtotal,
    output logic [CW-1:0] vactive,
    output logic          valid,
    output logic          changed
);
    localparam logic [CW-1:0]      CNT_MAX   = '1;
    localparam logic [MATCH_W-1:0] MATCH_MAX = '1;
    localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(STABLE_FRAMES);

    logic hs_rise, vs_rise, de_s, ce_s;

    vtm_edge_det u_edge_det (
        .clk_vid (clk_vid),
        .reset_n (reset_n),
        .hs      (hs),
        .vs      (vs),
        .de      (de),
        .hs_rise (hs_rise),
        .vs_rise (vs_rise),
        .de_s    (de_s)
    );

    logic [CW-1:0]      pix_cnt, act_cnt, line_len, max_act, line_cnt, vact_cnt;
    logic [CW-1:0]      line_len_n, max_act_n, line_cnt_n, vact_cnt_n;
    logic               frame_bad, bad_n, pix_sat, act_sat, line_sat;
    logic [23:0]        to_cnt;
    logic               timeout, is_match, first_frame;
    logic [MATCH_W-1:0] match_cnt, match_inc;
    state_e             state;
    frame_t             cur_q, cand;

    // The line close is folded in here so an hs edge coinciding with vs lands in the closing frame.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pix_sat    = ce_s && !hs_rise && (pix_cnt == CNT_MAX);
        act_sat    = ce_s && de_s && !hs_rise && (act_cnt == CNT_MAX);
        line_sat   = hs_rise && (line_cnt == CNT_MAX);
        line_len_n = line_len;
        max_act_n  = max_act;
        line_cnt_n = line_cnt;
        vact_cnt_n = vact_cnt;
        if (hs_rise) begin
            line_len_n = pix_cnt;
            max_act_n  = (act_cnt > max_act) ? act_cnt : max_act;
            if (!line_sat)
                line_cnt_n = line_cnt + 1'b1;
            if ((act_cnt != '0) && (vact_cnt != CNT_MAX))
                vact_cnt_n = vact_cnt + 1'b1;
        end
        bad_n     = frame_bad | pix_sat | act_sat | line_sat;
        cand      = '{htotal:  CW_MAX'(line_len_n), hactive: CW_MAX'(max_act_n),
                      vtotal:  CW_MAX'(line_cnt_n), vactive: CW_MAX'(vact_cnt_n)};
        is_match  = !first_frame && !bad_n && (cand == cur_q);
        match_inc = (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + 1'b1;
        timeout   = (to_cnt == TIMEOUT);
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            ce_s      <= 1'b0;
            pix_cnt   <= '0;
            act_cnt   <= '0;
            line_len  <= '0;
            max_act   <= '0;
            line_cnt  <= '0;
            vact_cnt  <= '0;
            frame_bad <= 1'b0;
            to_cnt    <= '0;
        end else begin
            ce_s <= ce_pix;
            if (timeout) begin
                pix_cnt   <= '0;
                act_cnt   <= '0;
                line_len  <= '0;
                max_act   <= '0;
                line_cnt  <= '0;
                vact_cnt  <= '0;
                frame_bad <= 1'b0;
                to_cnt    <= '0;
            end else begin
                to_cnt <= hs_rise ? '0 : to_cnt + 1'b1;
                // A pixel on the hs edge itself is pixel 1 of the new line.
                if (hs_rise)
                    pix_cnt <= CW'(ce_s);
                else if (ce_s && !pix_sat)
                    pix_cnt <= pix_cnt + 1'b1;
                if (hs_rise)
                    act_cnt <= CW'(ce_s && de_s);
                else if (ce_s && de_s && !act_sat)
                    act_cnt <= act_cnt + 1'b1;
                line_len <= line_len_n;
                if (vs_rise) begin
                    max_act   <= '0;
                    line_cnt  <= '0;
                    vact_cnt  <= '0;
                    frame_bad <= 1'b0;
                end else begin
                    max_act   <= max_act_n;
                    line_cnt  <= line_cnt_n;
                    vact_cnt  <= vact_cnt_n;
                    frame_bad <= bad_n;
                end
            end
        end
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            match_cnt   <= '0;
            first_frame <= 1'b0;
            valid       <= 1'b0;
            changed     <= 1'b0;
            cur_q       <= '0;
        end else begin
            changed <= 1'b0;
            if (timeout) begin
                state     <= IDLE;
                valid     <= 1'b0;
                match_cnt <= '0;
            end else if (vs_rise) begin
                if (state == IDLE) begin
                    state       <= MEASURE;
                    first_frame <= 1'b1;
                end else begin
                    cur_q       <= cand;
                    first_frame <= 1'b0;
                    if (is_match) begin
                        match_cnt <= match_inc;
                        if (match_inc >= MATCH_TGT) begin
                            valid <= 1'b1;
                            state <= LOCKED;
                        end
                    end else begin
                        match_cnt <= '0;
                        valid     <= 1'b0;
                        changed   <= !first_frame;
                        state     <= MEASURE;
                    end
                end
            end
        end
    end

    assign htotal  = cur_q.htotal[CW-1:0];
    assign hactive = cur_q.hactive[CW-1:0];
    assign vtotal  = cur_q.vtotal[CW-1:0];
    assign vactive = cur_q.vactive[CW-1:0];

endmodule

// File: tb/tb_video_timing_meter.sv
// Bench for video_timing_meter on a scaled-down raster (20x12 lines, 16x8 active,
// ce_pix every other clock); expected frame results go through a scoreboard queue.
module tb_video_timing_meter;

    localparam int          CW      = 6;
    localparam logic [23:0] TMO     = 24'd400;
    localparam int          V_TOT   = 12;
    localparam int          V_ACT   = 8;

    typedef struct {
        longint due;
        int     ht, ha, vt, va;
        bit     valid, chg;
    } exp_t;

    typedef struct {
        int   ht, ha, off;
        exp_t e;
    } vec_t;

    logic          clk_vid = 1'b0;
    logic          reset_n, ce_pix, hs, vs, de;
    logic [CW-1:0] htotal, hactive, vtotal, vactive;
    logic          valid, changed;

    longint cyc = 0;
    int     n_cmp = 0, n_fail = 0, chg_seen = 0, n_frm = 0;
    exp_t   sb_q[$];

    video_timing_meter #(.CW(CW), .STABLE_FRAMES(2), .TIMEOUT(TMO)) dut (
        .clk_vid (clk_vid),
        .reset_n (reset_n),
        .ce_pix  (ce_pix),
        .hs      (hs),
        .vs      (vs),
        .de      (de),
        .htotal  (htotal),
        .hactive (hactive),
        .vtotal  (vtotal),
        .vactive (vactive),
        .valid   (valid),
        .changed (changed)
    );

    always #5 clk_vid = ~clk_vid;
    always @(posedge clk_vid) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int ht, ha, vt, va, input bit v, c);
        exp_t e;
        e.due = 0; e.ht = ht; e.ha = ha; e.vt = vt; e.va = va; e.valid = v; e.chg = c;
        return e;
    endfunction

    // Scoreboard side: results are due two edges after the vs rise was driven.
    always @(negedge clk_vid) begin
        if (changed) chg_seen++;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("frm%0d.htotal", n_frm),  int'(htotal),  e.ht);
            check($sformatf("frm%0d.hactive", n_frm), int'(hactive), e.ha);
            check($sformatf("frm%0d.vtotal", n_frm),  int'(vtotal),  e.vt);
            check($sformatf("frm%0d.vactive", n_frm), int'(vactive), e.va);
            check($sformatf("frm%0d.valid", n_frm),   int'(valid),   int'(e.valid));
            check($sformatf("frm%0d.changed", n_frm), int'(changed), int'(e.chg));
            n_frm++;
        end
    end

    // hs pulses at pixels 0-1; vs rises on line 0 at pixel 'off'; de on the trailing pixels of the last V_ACT lines.
    task automatic drive_frame(input int ht, ha, off, nl, input exp_t e);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < ht; p++) begin
                logic h_v, v_v, d_v;
                h_v = (p < 2);
                v_v = (l == 0 && p >= off) || (l == 1) || (l == 2 && p < off);
                d_v = (l >= V_TOT - V_ACT) && (p >= ht - ha);
                @(negedge clk_vid);
                if (l == 0 && p == off) begin
                    e.due = cyc + 2;
                    sb_q.push_back(e);
                end
                hs = h_v; vs = v_v; de = d_v; ce_pix = 1'b1;
                @(negedge clk_vid);
                ce_pix = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_vid);
            hs = 1'b0; vs = 1'b0; de = 1'b0; ce_pix = (i % 2 == 0);
        end
    endtask

    task automatic check_outs(input string tag, input int ht, ha, vt, va, input bit v);
        check({tag, ".htotal"},  int'(htotal),  ht);
        check({tag, ".hactive"}, int'(hactive), ha);
        check({tag, ".vtotal"},  int'(vtotal),  vt);
        check({tag, ".vactive"}, int'(vactive), va);
        check({tag, ".valid"},   int'(valid),   int'(v));
        check({tag, ".changed"}, int'(changed), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "bench time limit expired");
    end

    initial begin
        vec_t tbl[17];
        int   exp_chg;
        reset_n = 1'b0; ce_pix = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;

        // Each row: geometry driven, and the result expected at the vs rise that starts it.
        tbl[0]  = '{20, 16, 5, mk( 0,  0,  0, 0, 0, 0)};
        tbl[1]  = '{20, 16, 5, mk(20, 16, 12, 8, 0, 0)};
        tbl[2]  = '{20, 16, 5, mk(20, 16, 12, 8, 0, 0)};
        tbl[3]  = '{20, 16, 5, mk(20, 16, 12, 8, 1, 0)};
        tbl[4]  = '{21, 16, 5, mk(20, 16, 12, 8, 1, 0)};
        tbl[5]  = '{20, 16, 5, mk(21, 16, 12, 8, 0, 1)};
        tbl[6]  = '{20, 16, 5, mk(20, 16, 12, 8, 0, 1)};
        tbl[7]  = '{20, 16, 5, mk(20, 16, 12, 8, 0, 0)};
        tbl[8]  = '{20, 16, 0, mk(20, 16, 12, 8, 1, 0)};
        tbl[9]  = '{20, 16, 0, mk(20, 16, 12, 8, 1, 0)};
        tbl[10] = '{20, 16, 5, mk(20, 16, 12, 8, 1, 0)};
        tbl[11] = '{70, 16, 5, mk(20, 16, 12, 8, 1, 0)};
        tbl[12] = '{70, 16, 5, mk(63, 16, 12, 8, 0, 1)};
        tbl[13] = '{20, 16, 5, mk(63, 16, 12, 8, 0, 1)};
        tbl[14] = '{20, 16, 5, mk(20, 16, 12, 8, 0, 1)};
        tbl[15] = '{20, 16, 5, mk(20, 16, 12, 8, 0, 0)};
        tbl[16] = '{20, 16, 5, mk(20, 16, 12, 8, 1, 0)};

        repeat (3) @(negedge clk_vid);
        check_outs("reset", 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        exp_chg = 0;
        for (int i = 0; i < 17; i++) begin
            drive_frame(tbl[i].ht, tbl[i].ha, tbl[i].off, V_TOT, tbl[i].e);
            exp_chg += int'(tbl[i].e.chg);
        end

        // hs stops while locked: watchdog drops valid and holds the last measurement.
        idle(450);
        check_outs("timeout", 20, 16, 12, 8, 0);
        check("timeout.chg_count", chg_seen, exp_chg);

        // Restart: arm, first frame, then two matches, same as from reset.
        drive_frame(20, 16, 5, V_TOT, mk(20, 16, 12, 8, 0, 0));
        drive_frame(20, 16, 5, V_TOT, mk(20, 16, 12, 8, 0, 0));
        drive_frame(20, 16, 5, V_TOT, mk(20, 16, 12, 8, 0, 0));
        drive_frame(20, 16, 5, V_TOT, mk(20, 16, 12, 8, 1, 0));
        drive_frame(20, 16, 5, 4,     mk(20, 16, 12, 8, 1, 0));

        // Reset mid-frame clears outputs without waiting for a clock edge.
        @(negedge clk_vid);
        hs = 1'b1; de = 1'b1; ce_pix = 1'b1;
        reset_n = 1'b0;
        #1;
        check_outs("midreset", 0, 0, 0, 0, 0);
        idle(6);
        reset_n = 1'b1;
        drive_frame(20, 16, 5, V_TOT, mk( 0,  0,  0, 0, 0, 0));
        drive_frame(20, 16, 5, V_TOT, mk(20, 16, 12, 8, 0, 0));
        drive_frame(20, 16, 5, 3,     mk(20, 16, 12, 8, 0, 0));
        idle(6);

        check("sb.pending", sb_q.size(), 0);
        check("final.chg_count", chg_seen, exp_chg);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
